mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ASZ, default 17, SHALL be the byte-address width of the shared RAM bus.
REQ-002 Parameter STARVE, default 4, SHALL be the number of consecutive denied debug-request cycles after which debug wins priority.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 c_req / c_we  input  1/1  SHALL be the core access request and its write qualifier.
REQ-006 c_ai / c_vi  input  ASZ/8  SHALL be the core byte address and write data.
REQ-007 c_gnt / c_rvld  output  1/1  SHALL be the core grant (same cycle) and the core read-data-valid (next cycle).
REQ-008 d_req / d_we / d_lock  input  1/1/1  SHALL be the debug port (ROM loader, dumper) request, write qualifier, and bus-lock hold.
REQ-009 d_ai / d_vi  input  ASZ/8  SHALL be the debug byte address and write data.
REQ-010 d_gnt / d_rvld  output  1/1  SHALL be the debug grant and the debug read-data-valid.
REQ-011 m_ai / m_vi / m_we  output  ASZ/8/1  SHALL drive the RAM byte bus address, write data and write enable.
REQ-012 m_vo  input  8  SHALL be RAM read data, valid one cycle after the address is presented.
REQ-013 rd_vo  output  8  SHALL be m_vo passed through combinationally to both requesters.

Function
REQ-014 State register SHALL hold one of IDLE, CORE, DBG, LOCK: the owner of the previous cycle's grant (IDLE = no grant).
REQ-015 At most one of c_gnt, d_gnt SHALL be high in any cycle; grants are combinational from the current requests, state and starve count.
REQ-016 Outside LOCK: c_gnt = c_req and (starve_cnt < STARVE); d_gnt = d_req and not c_gnt.
REQ-017 In LOCK: d_gnt = d_req; c_gnt SHALL be 0 regardless of c_req.
REQ-018 Next state: LOCK if d_gnt and d_lock; else LOCK remains LOCK while d_lock = 1 even when d_req = 0; else CORE if c_gnt, DBG if d_gnt, IDLE otherwise.
REQ-019 LOCK SHALL exit at the first edge with d_lock = 0; that cycle is arbitrated normally per REQ-016.
REQ-020 starve_cnt (width clog2(STARVE+1)) SHALL increment by 1 on each edge with d_req = 1 and d_gnt = 0, saturate at STARVE, and clear on d_gnt = 1 or d_req = 0.
REQ-021 m_ai/m_vi SHALL mux from the granted requester; with no grant they SHALL hold the core's c_ai/c_vi; m_we = (c_gnt and c_we) or (d_gnt and d_we).
REQ-022 c_rvld SHALL be registered (c_gnt and not c_we); d_rvld SHALL be registered (d_gnt and not d_we); fixed 1-cycle read latency; back-to-back reads SHALL give one valid per cycle.
REQ-023 Writes SHALL complete in the grant cycle; no rvld is produced for a write.
REQ-024 A requester not granted SHALL hold its request and operands; the arbiter SHALL not queue requests.

Reset
REQ-025 On rst = 1 at an edge: state = IDLE, starve_cnt = 0, c_rvld = 0, d_rvld = 0.
REQ-026 While rst = 1, c_gnt, d_gnt and m_we SHALL be forced to 0.
REQ-027 Reset asserted in LOCK SHALL release the lock; the first cycle after reset SHALL arbitrate per REQ-016 from IDLE.

Verification
REQ-028 Core read 0x0001, m_vo = 0x12 next cycle -> c_gnt same cycle, m_ai = 0x0001, c_rvld = 1 and rd_vo = 0x12 one cycle later, d_rvld = 0.
REQ-029 c_req and d_req held high continuously, STARVE = 4 -> core granted 4 cycles, debug granted on 5th, counter clears, pattern repeats (4:1).
REQ-030 Debug write 0x0050 <- 0xA5 with d_lock = 1, then c_req = 1 for 6 cycles -> m_we = 1 once, state LOCK, c_gnt = 0 throughout, c_gnt = 1 in the cycle d_lock falls.
REQ-031 Debug burst reads 0x0100..0x010F with d_lock = 1 -> 16 consecutive d_rvld pulses, each one cycle after its address, no core grant.
REQ-032 rst asserted mid-LOCK with c_req = 1 -> all grants 0 during reset, state IDLE, core granted in first cycle after rst falls.
REQ-033 No requests for 3 cycles -> grants 0, m_we = 0, state IDLE, starve_cnt 0.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port byte-bus arbiter: core vs. debug loader/dumper, with debug anti-starvation
// and a debug-held bus lock. Read data returns one cycle after the granted address.
module mem_arb #(
    parameter int ASZ    = 17,
    parameter int STARVE = 4
) (
    input  logic           clk,
    input  logic           rst,
    // core port
    input  logic           c_req,
    input  logic           c_we,
    input  logic [ASZ-1:0] c_ai,
    input  logic [7:0]     c_vi,
    output logic           c_gnt,
    output logic           c_rvld,
    // debug port
    input  logic           d_req,
    input  logic           d_we,
    input  logic           d_lock,
    input  logic [ASZ-1:0] d_ai,
    input  logic [7:0]     d_vi,
    output logic           d_gnt,
    output logic           d_rvld,
    // RAM byte bus
    output logic [ASZ-1:0] m_ai,
    output logic [7:0]     m_vi,
    output logic           m_we,
    input  logic [7:0]     m_vo,
    output logic [7:0]     rd_vo
);

    localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_starve_cnt;
    logic [CW-1:0]   w_starve_nxt;
    logic            r_c_rvld;
    logic            r_d_rvld;
    logic            w_c_gnt;
    logic            w_d_gnt;
    logic            w_lock_hold;

    // The lock only holds while d_lock stays high; the cycle it drops is arbitrated normally.
    assign w_lock_hold = (r_state == LOCK) && d_lock;

    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (w_lock_hold) begin
                w_d_gnt = d_req;
            end else begin
                w_c_gnt = c_req && (r_starve_cnt < STARVE_MAX);
                w_d_gnt = d_req && !w_c_gnt;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (w_d_gnt && d_lock) begin
            w_state_nxt = LOCK;
        end else if (w_lock_hold) begin
            w_state_nxt = LOCK;
        end else if (w_c_gnt) begin
            w_state_nxt = CORE;
        end else if (w_d_gnt) begin
            w_state_nxt = DBG;
        end
    end

    // Counts consecutive denied debug cycles; saturates so debug keeps winning until served.
    always_comb begin
        w_starve_nxt = '0;
        if (d_req && !w_d_gnt) begin
            w_starve_nxt = (r_starve_cnt == STARVE_MAX) ? STARVE_MAX : r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_c_rvld     <= 1'b0;
            r_d_rvld     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_c_rvld     <= w_c_gnt && !c_we;
            r_d_rvld     <= w_d_gnt && !d_we;
        end
    end

    assign c_gnt  = w_c_gnt;
    assign d_gnt  = w_d_gnt;
    assign c_rvld = r_c_rvld;
    assign d_rvld = r_d_rvld;
    assign m_ai   = w_d_gnt ? d_ai : c_ai;
    assign m_vi   = w_d_gnt ? d_vi : c_vi;
    assign m_we   = (w_c_gnt && c_we) || (w_d_gnt && d_we);
    assign rd_vo  = m_vo;

endmodule
